serial_frame_tx: RTL and testbench

Serial frame transmitter. Accepts a parallel payload word over a valid/ready handshake and drives it onto a one-bit serial line, prefixed by a fixed sync pattern (default 10110) that the downstream serial pattern detector locks onto. Sits on the transmit side of the single-wire test link: the register stage feeds it and `data_out` drives the detector's `data_in`.

---
 rtl/serial_frame_tx_if.sv | 26 ++
 rtl/serial_frame_tx.sv | 154 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx_if
// Description : Payload valid/ready handshake into the serial frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Sends a sync pattern then the latched payload MSB first on a
//               one-bit line, followed by a low gap bit. Define
//               SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 5,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 5'b10110
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_frame_tx_if.slave in_if,
    output logic             data_out,
    output logic             frame_active,
    output logic             done
);

    localparam int c_max_w = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
    localparam int c_cnt_w = $clog2(c_max_w);

    localparam logic [c_cnt_w-1:0] c_sync_last = c_cnt_w'(SYNC_W - 1);
    localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                data_out_q, data_out_d;
    logic                frame_active_q, frame_active_d;
    logic                done_q, done_d;
    logic [SYNC_W-1:0]   w_sync_shifted;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // Shifting the pattern keeps the select generic when the counter is
    // wider than the sync pattern index.
    assign w_sync_shifted = SYNC_PAT >> cnt_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        data_out_d     = 1'b0;
        frame_active_d = 1'b0;
        done_d         = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d       = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_if.in_valid) begin
                    shift_d  = in_if.in_data;
                    cnt_d    = c_sync_last;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d = ^in_if.in_data;
`endif
                    state_d  = ST_SYNC;
                end
            end
            ST_SYNC: begin
                data_out_d     = w_sync_shifted[0];
                frame_active_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = c_data_last;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            ST_DATA: begin
                data_out_d     = shift_q[DATA_W-1];
                frame_active_d = 1'b1;
                shift_d        = {shift_q[DATA_W-2:0], 1'b0};
                if (cnt_q == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_GAP;
`endif
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            ST_PARITY: begin
                data_out_d     = parity_q;
                frame_active_d = 1'b1;
                state_d        = ST_GAP;
            end
`endif
            ST_GAP: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            data_out_q     <= 1'b0;
            frame_active_q <= 1'b0;
            done_q         <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            data_out_q     <= data_out_d;
            frame_active_q <= frame_active_d;
            done_q         <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    // Ready is decoded combinationally so it drops in the same cycle as rst.
    assign in_if.in_ready = (state_q == ST_IDLE) && !rst;
    assign data_out       = data_out_q;
    assign frame_active   = frame_active_q;
    assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Scoreboard bench for serial_frame_tx; honours
//               SERIAL_FRAME_TX_PARITY_EN when predicting frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    localparam int                DATA_W   = 8;
    localparam int                SYNC_W   = 5;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 5'b10110;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = SYNC_W + DATA_W + PAR_BITS;

    typedef struct {
        int   cyc;
        logic dout;
        logic fa;
        logic dn;
    } exp_t;

    logic clk;
    logic rst;
    logic data_out;
    logic frame_active;
    logic done;

    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   next_ok = 0;
    int   acc_cnt = 0;
    bit   mon_en  = 1'b0;
    exp_t exp_q[$];

    serial_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_tx #(
        .DATA_W   (DATA_W),
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_if        (bus.slave),
        .data_out     (data_out),
        .frame_active (frame_active),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: an accepted word becomes a list of line values,
    // one per future edge index, built straight from the frame layout.
    task automatic model_edge(input logic r, input logic v, input logic [DATA_W-1:0] d);
        int                k;
        int                ones;
        exp_t              e;
        logic [SYNC_W-1:0] pat;
        k   = cyc;
        pat = SYNC_PAT;
        if (r) begin
            exp_q.delete();
            next_ok = k + 1;
        end else if (v && k >= next_ok) begin
            acc_cnt++;
            for (int i = 0; i < SYNC_W; i++) begin
                e.cyc = k + 1 + i; e.dout = pat[SYNC_W-1-i]; e.fa = 1'b1; e.dn = 1'b0;
                exp_q.push_back(e);
            end
            ones = 0;
            for (int i = 0; i < DATA_W; i++) begin
                e.cyc = k + 1 + SYNC_W + i; e.dout = d[DATA_W-1-i]; e.fa = 1'b1; e.dn = 1'b0;
                exp_q.push_back(e);
                ones += int'(d[i]);
            end
            if (PAR_BITS == 1) begin
                e.cyc = k + 1 + SYNC_W + DATA_W; e.dout = logic'(ones % 2); e.fa = 1'b1; e.dn = 1'b0;
                exp_q.push_back(e);
            end
            e.cyc = k + NBITS + 1; e.dout = 1'b0; e.fa = 1'b0; e.dn = 1'b1;
            exp_q.push_back(e);
            next_ok = k + NBITS + 2;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        model_edge(r, v, d);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        while (cyc + 1 < next_ok) step(1'b0, 1'b0, DATA_W'($urandom));
        step(1'b0, 1'b1, d);
    endtask

    task automatic check_cycle();
        exp_t e;
        logic exp_rdy;
        e.cyc = cyc; e.dout = 1'b0; e.fa = 1'b0; e.dn = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        checks++;
        if ({data_out, frame_active, done} !== {e.dout, e.fa, e.dn}) begin
            errors++;
            $display("FAIL line_out @edge %0d: data_out/frame_active/done got %b%b%b expected %b%b%b",
                     cyc, data_out, frame_active, done, e.dout, e.fa, e.dn);
        end
        exp_rdy = (cyc + 1 >= next_ok) && !rst;
        checks++;
        if (bus.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready @edge %0d: got %b expected %b", cyc, bus.in_ready, exp_rdy);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) check_cycle();
        end
    end

    initial begin
        int a0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        step(1'b1, 1'b0, '0);
        mon_en = 1'b1;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        repeat (10) step(1'b0, 1'b0, DATA_W'($urandom));

        // Single frame; in_data is scrambled while it is on the line.
        send(8'hA5);
        repeat (16) step(1'b0, 1'b0, DATA_W'($urandom));

        // in_valid held high: back-to-back 0x00 then 0xFF.
        a0 = acc_cnt;
        while (acc_cnt == a0) step(1'b0, 1'b1, 8'h00);
        a0 = acc_cnt;
        while (acc_cnt == a0) step(1'b0, 1'b1, 8'hFF);
        repeat (16) step(1'b0, 1'b0, DATA_W'($urandom));

        // Reset landing mid-payload, then a fresh frame.
        send(8'hA5);
        repeat (7) step(1'b0, 1'b0, DATA_W'($urandom));
        step(1'b1, 1'b0, DATA_W'($urandom));
        step(1'b0, 1'b0, DATA_W'($urandom));
        send(8'h3C);
        repeat (16) step(1'b0, 1'b0, DATA_W'($urandom));

        send(8'h07);
        repeat (17) step(1'b0, 1'b0, DATA_W'($urandom));

        repeat (400) step(($urandom % 60) == 0, ($urandom % 3) == 0, DATA_W'($urandom));
        repeat (20) step(1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
